// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one byte per frame from an upstream FIFO and sends it LSB-first on tx.
// Define UART_TX_PARITY_EN to add an even parity bit (11-bit frames); otherwise frames are 8N1.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_PRE_LAST = CW'(CLKS_PER_BIT - 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

    state_t        state_reg, state_next;
    logic [7:0]    shift_reg, shift_next;
    logic [CW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic          tx_reg, tx_next;
    logic          rd_reg, rd_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
`ifdef UART_TX_PARITY_EN
    logic          parity_reg, parity_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            baud_reg  <= '0;
            bit_reg   <= '0;
            tx_reg    <= 1'b1;
            rd_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            tx_reg    <= tx_next;
            rd_reg    <= rd_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Outputs are registered: each *_next is the value seen in the cycle after the edge.
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        tx_next    = tx_reg;
        rd_next    = 1'b0;
        done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_next = FETCH;
                    rd_next    = 1'b1;
                end
            end
            FETCH: state_next = LOAD;
            LOAD: begin
                shift_next = fifo_dout;
`ifdef UART_TX_PARITY_EN
                parity_next = ^fifo_dout;
`endif
                baud_next  = '0;
                bit_next   = '0;
                tx_next    = 1'b0;
                state_next = START;
            end
            START: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next  = '0;
                    tx_next    = shift_reg[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = parity_reg;
                        state_next = PARITY;
`else
                        tx_next    = 1'b1;
                        state_next = STOP;
`endif
                    end else begin
                        tx_next = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next  = '0;
                    tx_next    = 1'b1;
                    state_next = STOP;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_reg + 1'b1;
                    // registered pulse lands on the final stop-bit cycle
                    done_next = (baud_reg == BAUD_PRE_LAST);
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    assign fifo_rd_en = rd_reg;
    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: randomized and directed checks of fifo_uart_tx against a frame-timing model.
// Compile with UART_TX_PARITY_EN defined to check the parity build.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FLEN = NBITS * CPB;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst(rst),
        .tx_en(tx_en),
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .tx(tx),
        .busy(busy),
        .frame_done(frame_done)
    );

    int    errors = 0;
    int    checks = 0;
    int    cyc_n = 0;
    int    next_free = 0;
    string tname = "init";
    bit    prev_rd = 1'b0;
    logic [7:0] q[$];
    logic [7:0] m_q[$];
    logic exp_tx[MAXC], exp_rd[MAXC], exp_busy[MAXC], exp_done[MAXC];
    logic act_tx[MAXC], act_rd[MAXC], act_done[MAXC];

    // Level of frame bit k for byte b: start, data LSB-first, optional even parity, stop.
    function automatic logic frame_bit(logic [7:0] b, int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // A pop decided at edge e: rd in cycle e, tx falls at e+2, frame lasts FLEN, idle again at e+2+FLEN.
    task automatic predict(int e);
        logic [7:0] b;
        b = m_q.pop_front();
        exp_rd[e] = 1'b1;
        for (int c = e; c <= e + 1 + FLEN; c++) exp_busy[c] = 1'b1;
        for (int k = 0; k < NBITS; k++)
            for (int j = 0; j < CPB; j++) exp_tx[e + 2 + k*CPB + j] = frame_bit(b, k);
        exp_done[e + 1 + FLEN] = 1'b1;
        next_free = e + 3 + FLEN;
    endtask

    task automatic clear_expect(int from);
        for (int c = from; c < MAXC; c++) begin
            exp_tx[c] = 1'b1; exp_rd[c] = 1'b0; exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        cyc_n++;
        if (cyc_n >= MAXC - FLEN - 8) begin
            $display("FAIL cycle_budget: cycle %0d exceeds limit %0d", cyc_n, MAXC - FLEN - 8);
            $fatal(1, "cycle budget exhausted");
        end
        if (rst === 1'b0 && cyc_n >= next_free && tx_en === 1'b1 && m_q.size() > 0) predict(cyc_n);
        #1;
        if (prev_rd) begin
            if (q.size() > 0) fifo_dout = q.pop_front();
            else fifo_dout = 8'($urandom);
        end
        prev_rd    = fifo_rd_en;
        fifo_empty = (q.size() == 0);
        act_tx[cyc_n] = tx; act_rd[cyc_n] = fifo_rd_en; act_done[cyc_n] = frame_done;
        checks++;
        if (tx !== exp_tx[cyc_n] || fifo_rd_en !== exp_rd[cyc_n] ||
            busy !== exp_busy[cyc_n] || frame_done !== exp_done[cyc_n]) begin
            errors++;
            $display("FAIL %s cycle %0d: tx=%b exp %b rd=%b exp %b busy=%b exp %b done=%b exp %b",
                     tname, cyc_n, tx, exp_tx[cyc_n], fifo_rd_en, exp_rd[cyc_n],
                     busy, exp_busy[cyc_n], frame_done, exp_done[cyc_n]);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic push(logic [7:0] b);
        q.push_back(b);
        m_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_pop(output int p);
        p = -1;
        for (int i = 0; i < 200 && p < 0; i++) begin
            cyc();
            if (act_rd[cyc_n] === 1'b1) p = cyc_n;
        end
        if (p < 0) begin
            errors++; checks++;
            $display("FAIL %s pop_timeout: no fifo_rd_en within 200 cycles, required one", tname);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s async_reset: tx=%b busy=%b rd=%b done=%b, required 1 0 0 0",
                     tname, tx, busy, fifo_rd_en, frame_done);
        end
        clear_expect(cyc_n + 1);
        prev_rd = 1'b0;
        next_free = 0;
        run(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tname = "reset";
        rst = 1'b1; tx_en = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00;
        clear_expect(0);
        #2;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b rd=%b done=%b, required 1 0 0 0",
                     tx, busy, fifo_rd_en, frame_done);
        end
        run(3);
        rst = 1'b0;
        run(3);
    endtask

    task automatic test_single();
        int p, n_rd, n_done;
`ifdef UART_TX_PARITY_EN
        logic lv[NBITS] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1};
`else
        logic lv[NBITS] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1};
`endif
        tname = "single_a5";
        push(8'hA5);
        tx_en = 1'b1;
        wait_pop(p);
        run(FLEN + 10);
        tx_en = 1'b0;
        if (p >= 0) begin
            n_rd = 0; n_done = 0;
            for (int c = p; c <= cyc_n; c++) begin
                n_rd += int'(act_rd[c]);
                n_done += int'(act_done[c]);
            end
            checks++;
            if (n_rd != 1 || n_done != 1) begin
                errors++;
                $display("FAIL single_counts: rd cycles=%0d done pulses=%0d, required 1 and 1", n_rd, n_done);
            end
            checks++;
            if (act_done[p + 1 + FLEN] !== 1'b1) begin
                errors++;
                $display("FAIL single_done_pos: frame_done at tx_fall+%0d is %b, required 1", FLEN - 1, act_done[p + 1 + FLEN]);
            end
            for (int k = 0; k < NBITS; k++) begin
                logic same;
                same = 1'b1;
                for (int j = 0; j < CPB; j++) if (act_tx[p + 2 + k*CPB + j] !== lv[k]) same = 1'b0;
                checks++;
                if (!same) begin
                    errors++;
                    $display("FAIL single_level bit %0d: tx=%b, required %b for %0d cycles",
                             k, act_tx[p + 2 + k*CPB], lv[k], CPB);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pops[$];
        int start;
        tname = "back_to_back";
        push(8'h00); push(8'hFF); push(8'h3C);
        start = cyc_n;
        tx_en = 1'b1;
        run(3 * (FLEN + 3) + 10);
        for (int c = start; c <= cyc_n; c++) if (act_rd[c] === 1'b1) pops.push_back(c);
        checks++;
        if (pops.size() != 3) begin
            errors++;
            $display("FAIL b2b_pop_count: %0d pops, required 3", pops.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (pops[i] - pops[i-1] != FLEN + 3) begin
                    errors++;
                    $display("FAIL b2b_spacing %0d: %0d cycles, required %0d", i, pops[i] - pops[i-1], FLEN + 3);
                end
            end
        end
    endtask

    task automatic test_blocked();
        int p, raise;
        tname = "blocked_empty";
        tx_en = 1'b1;
        run(100);
        tname = "blocked_txen";
        tx_en = 1'b0;
        push(8'h5A);
        run(100);
        tname = "txen_raise";
        tx_en = 1'b1;
        raise = cyc_n;
        wait_pop(p);
        checks++;
        if (p != raise + 1) begin
            errors++;
            $display("FAIL txen_raise_latency: pop at cycle %0d, required %0d", p, raise + 1);
        end
        run(FLEN + 5);
    endtask

    task automatic test_reset_mid();
        int p;
        tname = "reset_mid";
        tx_en = 1'b1;
        push(8'hC3);
        wait_pop(p);
        run(2 + 3*CPB + CPB + 1);
        apply_reset();
        tname = "reset_mid_quiet";
        run(60);
        tname = "reset_mid_next";
        push(8'h96);
        run(FLEN + 10);
    endtask

    task automatic test_txen_drop();
        int p, n_rd;
        tname = "txen_drop";
        tx_en = 1'b1;
        push(8'h81); push(8'h42); push(8'hE7);
        wait_pop(p);
        run(3);
        tx_en = 1'b0;
        run(100);
        n_rd = 0;
        for (int c = p + 1; c <= cyc_n; c++) n_rd += int'(act_rd[c]);
        checks++;
        if (n_rd != 0) begin
            errors++;
            $display("FAIL txen_drop_no_pop: %0d extra pops, required 0", n_rd);
        end
        tx_en = 1'b1;
        run(2 * (FLEN + 3) + 5);
    endtask

    task automatic test_random();
        int guard;
        tname = "random";
        for (int r = 0; r < 15; r++) begin
            int n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) push(8'($urandom));
            tx_en = ($urandom_range(0, 3) != 0);
            run($urandom_range(10, 60));
        end
        tx_en = 1'b1;
        guard = 0;
        while ((m_q.size() > 0 || cyc_n < next_free + 2) && guard < 2000) begin
            cyc();
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL random_drain: %0d bytes left after 2000 cycles, required 0", m_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_blocked();
        test_reset_mid();
        test_txen_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
